// File: rtl/nios_sample_capture_master.sv
// Avalon-MM write master: captures I/Q pairs into the Nios on-chip RAM (s2 port) via an elastic
// FIFO. Optional input decimation is built when NIOS_SAMPLE_CAPTURE_DECIM_EN is defined.
module nios_sample_capture_master #(
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned MEM_WORDS  = 6000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] length,
`ifdef NIOS_SAMPLE_CAPTURE_DECIM_EN
    input  logic [7:0]        decim,
`endif
    output logic              busy,
    output logic              done,
    output logic              overflow,
    input  logic              iq_valid,
    input  logic [15:0]       i_data,
    input  logic [15:0]       q_data,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest
);

    localparam int unsigned CntW = ADDR_W + 1;
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LvlW = PtrW + 1;
    localparam logic [CntW-1:0]   MemWords = CntW'(MEM_WORDS);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MEM_WORDS - 1);
    localparam logic [LvlW-1:0]   Depth    = LvlW'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StCapture, StDrain, StAbort, StDone} state_e;

    state_e            state_q, state_d;
    logic              zero_done_q, zero_done_d;
    logic              overflow_q, overflow_d;
    logic [CntW-1:0]   target_q, target_d;
    logic [CntW-1:0]   accepted_q, accepted_d;
    logic [CntW-1:0]   written_q, written_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cs_q, cs_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       data_q, data_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic [31:0]       mem [FIFO_DEPTH];

    logic              pop, capturing, eligible, take, full, push, drop;
    logic              hit_target, finish, flush;
    logic [LvlW-1:0]   level_pop;
    logic [PtrW-1:0]   rd_pop;
    logic [CntW-1:0]   len_ext;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       push_word;

`ifdef NIOS_SAMPLE_CAPTURE_DECIM_EN
    logic [7:0] decim_q, decim_d;
    logic [7:0] dcnt_q, dcnt_d;
`endif

    always_comb begin
        pop        = cs_q & ~avm_waitrequest;
        capturing  = (state_q == StCapture) & ~abort;
`ifdef NIOS_SAMPLE_CAPTURE_DECIM_EN
        eligible   = iq_valid & (dcnt_q == 8'd0);
`else
        eligible   = iq_valid;
`endif
        take       = capturing & eligible & (accepted_q < target_q);
        full       = (level_q == Depth);
        // A pop completing this cycle frees a slot for a same-cycle push even when full.
        push       = take & (~full | pop);
        drop       = take & ~push;
        push_word  = {q_data, i_data};
        len_ext    = {1'b0, length};
        next_addr  = (addr_q == LastAddr) ? '0 : addr_q + ADDR_W'(1);

        level_pop  = level_q - LvlW'(pop);
        rd_pop     = rd_ptr_q + PtrW'(pop);

        state_d     = state_q;
        zero_done_d = 1'b0;
        overflow_d  = overflow_q | drop;
        target_d    = target_q;
        accepted_d  = accepted_q + CntW'(take);
        written_d   = written_q + CntW'(pop);
        addr_d      = pop ? next_addr : addr_q;
        level_d     = level_pop + LvlW'(push);
        rd_ptr_d    = rd_pop;
        wr_ptr_d    = wr_ptr_q + PtrW'(push);
        cs_d        = 1'b0;
        flush       = 1'b0;
`ifdef NIOS_SAMPLE_CAPTURE_DECIM_EN
        decim_d     = decim_q;
        dcnt_d      = dcnt_q;
        if (capturing && iq_valid && (accepted_q < target_q)) begin
            dcnt_d = (dcnt_q == decim_q) ? 8'd0 : dcnt_q + 8'd1;
        end
`endif

        hit_target = (accepted_d == target_q);
        // Dropped samples leave written short of target, so an empty FIFO also ends the run.
        finish     = hit_target & ((written_d == target_q) | (level_d == '0));

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (length == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        state_d    = StCapture;
                        target_d   = (len_ext > MemWords) ? MemWords : len_ext;
                        accepted_d = '0;
                        written_d  = '0;
                        overflow_d = 1'b0;
                        addr_d     = ADDR_W'({1'b0, start_addr} % MemWords);
`ifdef NIOS_SAMPLE_CAPTURE_DECIM_EN
                        decim_d    = decim;
                        dcnt_d     = 8'd0;
`endif
                    end
                end
            end
            StCapture, StDrain: begin
                if (abort) begin
                    state_d = StAbort;
                    cs_d    = cs_q & avm_waitrequest;
                end else begin
                    cs_d = (level_d != '0);
                    if (finish) begin
                        state_d = StDone;
                    end else if (hit_target) begin
                        state_d = StDrain;
                    end
                end
            end
            StAbort: begin
                // A stalled transfer must complete before the FIFO is discarded.
                cs_d = cs_q & avm_waitrequest;
                if (!(cs_q && avm_waitrequest)) begin
                    flush   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (flush) begin
            level_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end

        // New head: bypass the incoming sample when the FIFO is otherwise empty.
        data_d = data_q;
        if (cs_d) begin
            data_d = (level_pop == '0) ? push_word : mem[rd_pop];
        end
        be_d = cs_d ? 4'hF : 4'h0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            zero_done_q <= 1'b0;
            overflow_q  <= 1'b0;
            target_q    <= '0;
            accepted_q  <= '0;
            written_q   <= '0;
            addr_q      <= '0;
            cs_q        <= 1'b0;
            be_q        <= 4'h0;
            data_q      <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            zero_done_q <= zero_done_d;
            overflow_q  <= overflow_d;
            target_q    <= target_d;
            accepted_q  <= accepted_d;
            written_q   <= written_d;
            addr_q      <= addr_d;
            cs_q        <= cs_d;
            be_q        <= be_d;
            data_q      <= data_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
        end
    end

`ifdef NIOS_SAMPLE_CAPTURE_DECIM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            decim_q <= 8'd0;
            dcnt_q  <= 8'd0;
        end else begin
            decim_q <= decim_d;
            dcnt_q  <= dcnt_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    assign busy           = (state_q == StCapture) | (state_q == StDrain) | (state_q == StAbort);
    assign done           = (state_q == StDone) | zero_done_q;
    assign overflow       = overflow_q;
    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write      = cs_q;
    assign avm_byteenable = be_q;
    assign avm_writedata  = data_q;

endmodule

// File: tb/tb_nios_sample_capture_master.sv
// Self-checking bench for nios_sample_capture_master: vector table of plain captures plus
// hand-written stall, overflow, abort, zero-length, clamp and reset sequences.
module tb_nios_sample_capture_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [12:0] start_addr = '0;
    logic [12:0] length = '0;
`ifdef NIOS_SAMPLE_CAPTURE_DECIM_EN
    logic [7:0]  decim = 8'd0;
`endif
    logic        busy, done, overflow;
    logic        iq_valid = 1'b0;
    logic [15:0] i_data = '0;
    logic [15:0] q_data = '0;
    logic [12:0] avm_address;
    logic        avm_chipselect, avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int stall_cnt = 0;
    logic [12:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    logic        prev_stall = 1'b0;
    logic [12:0] held_addr = '0;
    logic [31:0] held_data = '0;

    nios_sample_capture_master dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .abort           (abort),
        .start_addr      (start_addr),
        .length          (length),
`ifdef NIOS_SAMPLE_CAPTURE_DECIM_EN
        .decim           (decim),
`endif
        .busy            (busy),
        .done            (done),
        .overflow        (overflow),
        .iq_valid        (iq_valid),
        .i_data          (i_data),
        .q_data          (q_data),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write       (avm_write),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Bus monitor: logs completed writes, checks strobes and hold-while-stalled.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("write_eq_cs", 32'(avm_write), 32'(avm_chipselect));
            if (avm_chipselect) chk("byteenable_on", 32'(avm_byteenable), 32'hF);
            else chk("byteenable_off", 32'(avm_byteenable), 32'h0);
            if (prev_stall) begin
                chk("stall_addr", 32'(avm_address), 32'(held_addr));
                chk("stall_data", avm_writedata, held_data);
                chk("stall_cs", 32'(avm_chipselect), 32'd1);
            end
            if (avm_chipselect && avm_waitrequest) begin
                if (!prev_stall) begin
                    held_addr = avm_address;
                    held_data = avm_writedata;
                end
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (avm_chipselect && !avm_waitrequest) begin
                wr_addr.push_back(avm_address);
                wr_data.push_back(avm_writedata);
                wr_cyc.push_back(cyc);
            end
            if (done) done_cnt++;
        end
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    // Continuous iq_valid with sample index k carrying {8000+k, 1000+k}.
    task automatic run_cap(input logic [12:0] sa, input logic [12:0] len, input int stall_at,
                           input int stall_len, input bit do_abort, input int max_cyc);
        int idx = 0;
        int d0 = done_cnt;
        bit aborted = 1'b0;
        bit ok = 1'b0;
        clear_log();
        stall_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; start_addr = sa; length = len; iq_valid = 1'b0; avm_waitrequest = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
            iq_valid = 1'b1;
            i_data = 16'h1000 + 16'(idx);
            q_data = 16'h8000 + 16'(idx);
            idx++;
            avm_waitrequest = 1'b0;
            if (stall_at >= 0 && wr_addr.size() == stall_at && avm_chipselect &&
                stall_cnt < stall_len) begin
                avm_waitrequest = 1'b1;
                stall_cnt++;
            end
            if (do_abort && !aborted && stall_cnt == 3) begin
                abort = 1'b1;
                aborted = 1'b1;
            end
        end
        iq_valid = 1'b0;
        avm_waitrequest = 1'b0;
        abort = 1'b0;
        chk("done_within_budget", 32'(ok), 32'd1);
        if (!ok) begin
            reset_n = 1'b0;
            @(posedge clk); #1;
            reset_n = 1'b1;
        end
    endtask

    task automatic verify(input string tag, input int n_exp, input logic [12:0] a0,
                          input int step, input logic ovf_exp);
        logic [12:0] a = a0;
        logic [15:0] s;
        chk({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(n_exp));
        for (int k = 0; k < n_exp && k < wr_addr.size(); k++) begin
            s = 16'(k * step);
            chk({tag, "_addr"}, 32'(wr_addr[k]), 32'(a));
            chk({tag, "_data"}, wr_data[k], {16'h8000 + s, 16'h1000 + s});
            a = (a == 13'd5999) ? 13'd0 : a + 13'd1;
        end
        chk({tag, "_overflow"}, 32'(overflow), 32'(ovf_exp));
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [12:0] sa;
        logic [12:0] len;
        int          n_exp;
        logic [12:0] a0;
    } vec_t;

    initial begin
        vec_t vecs[7];
        bit   got;
        int   d0;
        int   n;
        vecs[0] = '{sa: 13'd100,  len: 13'd1,  n_exp: 1,  a0: 13'd100};
        vecs[1] = '{sa: 13'd5998, len: 13'd4,  n_exp: 4,  a0: 13'd5998};
        vecs[2] = '{sa: 13'd6100, len: 13'd3,  n_exp: 3,  a0: 13'd100};
        vecs[3] = '{sa: 13'd0,    len: 13'd8,  n_exp: 8,  a0: 13'd0};
        vecs[4] = '{sa: 13'd5999, len: 13'd2,  n_exp: 2,  a0: 13'd5999};
        vecs[5] = '{sa: 13'd8191, len: 13'd5,  n_exp: 5,  a0: 13'd2191};
        vecs[6] = '{sa: 13'd200,  len: 13'd20, n_exp: 20, a0: 13'd200};

        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_cs", 32'(avm_chipselect), 32'd0);
        chk("rst_write", 32'(avm_write), 32'd0);
        chk("rst_be", 32'(avm_byteenable), 32'd0);
        chk("rst_addr", 32'(avm_address), 32'd0);
        chk("rst_data", avm_writedata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single word: latency, data, done one cycle after the write.
        clear_log();
        @(posedge clk); #1;
        start = 1'b1; start_addr = 13'd100; length = 13'd1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("sw_busy_after_start", 32'(busy), 32'd1);
        iq_valid = 1'b1; i_data = 16'hABCD; q_data = 16'h1234;
        @(posedge clk); #1;
        iq_valid = 1'b0;
        chk("sw_latency_cs", 32'(avm_chipselect), 32'd1);
        chk("sw_addr", 32'(avm_address), 32'd100);
        chk("sw_data", avm_writedata, 32'h1234ABCD);
        chk("sw_be", 32'(avm_byteenable), 32'hF);
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done) begin
                got = 1'b1;
                chk("sw_busy_with_done", 32'(busy), 32'd0);
                if (wr_cyc.size() > 0) chk("sw_done_delay", 32'(cyc - wr_cyc[0]), 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        chk("sw_done_seen", 32'(got), 32'd1);
        chk("sw_nwrites", 32'(wr_addr.size()), 32'd1);
        @(posedge clk); #1;
        chk("sw_done_pulse", 32'(done), 32'd0);

        // Stall on the 2nd write for 5 cycles.
        run_cap(13'd400, 13'd3, 1, 5, 1'b0, 60);
        chk("stall_cycles_applied", 32'(stall_cnt), 32'd5);
        verify("stall", 3, 13'd400, 1, 1'b0);

        // Overflow: 20-cycle stall on the first write with a 16-word capture.
        run_cap(13'd1000, 13'd16, 0, 20, 1'b0, 100);
        n = wr_addr.size();
        chk("ovf_nwrites_8_or_9", 32'((n == 8) || (n == 9)), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        for (int k = 0; k < 8 && k < n; k++) begin
            chk("ovf_data", wr_data[k], {16'h8000 + 16'(k), 16'h1000 + 16'(k)});
        end

        // Abort during a stall on the 4th write.
        d0 = done_cnt;
        run_cap(13'd300, 13'd10, 3, 6, 1'b1, 100);
        chk("abort_done_count", 32'(done_cnt - d0), 32'd1);
        verify("abort", 4, 13'd300, 1, 1'b0);

        // Plain captures; also confirms no stale FIFO words survive the abort.
        foreach (vecs[v]) begin
            run_cap(vecs[v].sa, vecs[v].len, -1, 0, 1'b0, 200);
            verify($sformatf("vec%0d", v), vecs[v].n_exp, vecs[v].a0, 1, 1'b0);
        end

        // Zero length: done next cycle, no bus activity.
        clear_log();
        @(posedge clk); #1;
        start = 1'b1; start_addr = 13'd50; length = 13'd0; iq_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("len0_done_cleared", 32'(done), 32'd0);
            chk("len0_no_cs", 32'(avm_chipselect), 32'd0);
        end
        iq_valid = 1'b0;
        chk("len0_nwrites", 32'(wr_addr.size()), 32'd0);

        // Length clamp: 7000 requested, 6000 written, wrapping back to start-1.
        run_cap(13'd10, 13'd7000, -1, 0, 1'b0, 6300);
        verify("clamp", 6000, 13'd10, 1, 1'b0);
        if (wr_addr.size() > 0) chk("clamp_last_addr", 32'(wr_addr[wr_addr.size() - 1]), 32'd9);

`ifdef NIOS_SAMPLE_CAPTURE_DECIM_EN
        decim = 8'd3;
        run_cap(13'd500, 13'd10, -1, 0, 1'b0, 100);
        verify("decim", 10, 13'd500, 4, 1'b0);
        decim = 8'd0;
`endif

        // Async reset mid-stall drops the strobes immediately.
        clear_log();
        @(posedge clk); #1;
        start = 1'b1; start_addr = 13'd20; length = 13'd5;
        @(posedge clk); #1;
        start = 1'b0; iq_valid = 1'b1;
        @(posedge clk); #1;
        iq_valid = 1'b0; avm_waitrequest = 1'b1;
        chk("rst_mid_cs_before", 32'(avm_chipselect), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_cs", 32'(avm_chipselect), 32'd0);
        chk("rst_mid_write", 32'(avm_write), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_overflow", 32'(overflow), 32'd0);
        avm_waitrequest = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_cap(13'd700, 13'd2, -1, 0, 1'b0, 50);
        verify("post_reset", 2, 13'd700, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
